// File: rtl/half_adder.sv
// ---------------------------------------------------------------------------
// half_adder
//   WIDTH independent half-adder lanes. Each lane has a combinational sum/carry
//   and a registered copy for timing-clean downstream use. There is no carry
//   between lanes.
//
//   Optional feature: define HALF_ADDER_STATS_EN to enable a saturating count
//   of accepted cycles that have any carry bit set. Without the macro,
//   carry_cnt is tied to zero and no counter logic is built.
//
// Ports
//   clk        rising-edge clock for all registers
//   rst        synchronous, active-high reset; takes priority over in_valid
//   a, b       addends, lane i = bit i
//   sum        a ^ b, combinational
//   carry      a & b, combinational
//   in_valid   qualifies a/b for the registered path
//   sum_q      registered sum; holds its value when in_valid=0
//   carry_q    registered carry; holds its value when in_valid=0
//   out_valid  one-cycle pulse for each accepted input
//   carry_cnt  saturating carry-event count (zero unless HALF_ADDER_STATS_EN)
// ---------------------------------------------------------------------------

// One lane: the combinational cell plus its enable-qualified output register.
module half_adder_lane (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry,
    output logic sum_q,
    output logic carry_q
);
    assign sum   = a ^ b;
    assign carry = a & b;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
        end else if (en) begin
            sum_q   <= sum;
            carry_q <= carry;
        end
    end
endmodule

module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);
    localparam int STAGES = 1;

    // Valid shift register. Stage 0 is the live input qualifier, and stage
    // STAGES lines up with sum_q/carry_q.
    logic [STAGES:0] vld_pipe;

    assign vld_pipe[0] = in_valid;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe[STAGES:1] <= '0;
        else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    assign out_valid = vld_pipe[STAGES];

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .en      (in_valid),
            .a       (a[i]),
            .b       (b[i]),
            .sum     (sum[i]),
            .carry   (carry[i]),
            .sum_q   (sum_q[i]),
            .carry_q (carry_q[i])
        );
    end

`ifdef HALF_ADDER_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    // The count stops at all-ones, so a long burst cannot wrap back to a
    // small value.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (in_valid && (|carry) && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
    end

    assign carry_cnt = cnt_q;
`else
    assign carry_cnt = '0;
`endif
endmodule

// File: tb/tb_half_adder.sv
module tb_half_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: single-bit cell, default counter width
    logic       rst1, iv1;
    logic [0:0] a1, b1, s1, c1, sq1, cq1;
    logic       ov1;
    logic [15:0] cnt1;

    // DUT 4: four lanes, 2-bit counter, used for the saturation check
    logic       rst4, iv4;
    logic [3:0] a4, b4, s4, c4, sq4, cq4;
    logic       ov4;
    logic [1:0] cnt4;

    half_adder #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst1), .a(a1), .b(b1), .sum(s1), .carry(c1),
        .in_valid(iv1), .sum_q(sq1), .carry_q(cq1), .out_valid(ov1),
        .carry_cnt(cnt1)
    );

    half_adder #(.WIDTH(4), .CNT_W(2)) u_dut4 (
        .clk(clk), .rst(rst4), .a(a4), .b(b4), .sum(s4), .carry(c4),
        .in_valid(iv4), .sum_q(sq4), .carry_q(cq4), .out_valid(ov4),
        .carry_cnt(cnt4)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected counter value once k carry events have been accepted, for the
    // given counter width.
    function automatic logic [31:0] exp_cnt(input int k, input int w);
`ifdef HALF_ADDER_STATS_EN
        int mx;
        mx = (1 << w) - 1;
        return (k > mx) ? mx : k;
`else
        return 0;
`endif
    endfunction

    // Hand-computed truth table, indexed by {a,b}.
    logic [1:0] ab_vec  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       exp_sum [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       exp_car [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int k1;
        k1 = 0;
        rst1 = 1; iv1 = 0; a1 = 0; b1 = 0;
        rst4 = 1; iv4 = 0; a4 = 0; b4 = 0;
        step();

        // Reset state
        chk("rst_sum_q",     {31'b0, sq1}, 0);
        chk("rst_carry_q",   {31'b0, cq1}, 0);
        chk("rst_out_valid", {31'b0, ov1}, 0);
        chk("rst_cnt1",      {16'b0, cnt1}, 0);
        chk("rst_cnt4",      {30'b0, cnt4}, 0);
        rst1 = 0; rst4 = 0;

        // Combinational sweep, each vector held for 250 ns
        for (int i = 0; i < 4; i++) begin
            a1 = ab_vec[i][1]; b1 = ab_vec[i][0];
            #1;
            chk($sformatf("comb_sum_%0d", i),   {31'b0, s1}, {31'b0, exp_sum[i]});
            chk($sformatf("comb_carry_%0d", i), {31'b0, c1}, {31'b0, exp_car[i]});
            #249;
            chk($sformatf("comb_hold_sum_%0d", i), {31'b0, s1}, {31'b0, exp_sum[i]});
            chk($sformatf("idle_out_valid_%0d", i), {31'b0, ov1}, 0);
        end

        // Registered sweep: result one edge later, out_valid high each cycle
        for (int i = 0; i < 4; i++) begin
            a1 = ab_vec[i][1]; b1 = ab_vec[i][0]; iv1 = 1;
            step();
            if (exp_car[i]) k1++;
            chk($sformatf("reg_sum_q_%0d", i),   {31'b0, sq1}, {31'b0, exp_sum[i]});
            chk($sformatf("reg_carry_q_%0d", i), {31'b0, cq1}, {31'b0, exp_car[i]});
            chk($sformatf("reg_out_valid_%0d", i), {31'b0, ov1}, 1);
            chk($sformatf("reg_cnt1_%0d", i), {16'b0, cnt1}, exp_cnt(k1, 16));
        end

        // Reset wins over in_valid; the combinational path is unaffected
        a1 = 1; b1 = 1; iv1 = 1; rst1 = 1;
        step();
        k1 = 0;
        chk("rstpri_sum_q",     {31'b0, sq1}, 0);
        chk("rstpri_carry_q",   {31'b0, cq1}, 0);
        chk("rstpri_out_valid", {31'b0, ov1}, 0);
        chk("rstpri_comb_carry", {31'b0, c1}, 1);
        chk("rstpri_cnt1",      {16'b0, cnt1}, 0);
        rst1 = 0;
        step();
        k1++;
        chk("postrst_carry_q",   {31'b0, cq1}, 1);
        chk("postrst_out_valid", {31'b0, ov1}, 1);
        chk("postrst_cnt1",      {16'b0, cnt1}, exp_cnt(k1, 16));

        // Single pulse, then hold: registers keep their value and out_valid drops
        a1 = 0; b1 = 0; iv1 = 0;
        step();
        chk("hold_carry_q",   {31'b0, cq1}, 1);
        chk("hold_sum_q",     {31'b0, sq1}, 0);
        chk("hold_out_valid", {31'b0, ov1}, 0);
        chk("hold_comb_carry", {31'b0, c1}, 0);
        chk("hold_cnt1",      {16'b0, cnt1}, exp_cnt(k1, 16));

        // Four lanes: no carry passes between lanes
        a4 = 4'b1100; b4 = 4'b1010; iv4 = 1;
        #1;
        chk("w4_sum",   {28'b0, s4}, 32'h6);
        chk("w4_carry", {28'b0, c4}, 32'h8);
        step();
        chk("w4_sum_q",     {28'b0, sq4}, 32'h6);
        chk("w4_carry_q",   {28'b0, cq4}, 32'h8);
        chk("w4_out_valid", {31'b0, ov4}, 1);
        chk("w4_cnt_1",     {30'b0, cnt4}, exp_cnt(1, 2));

        // An accepted cycle with no carry leaves the count unchanged
        a4 = 4'b0101; b4 = 4'b1010;
        step();
        chk("w4_nocarry_cnt", {30'b0, cnt4}, exp_cnt(1, 2));

        // Saturation: reset, then 5 carry events on a 2-bit counter
        rst4 = 1;
        step();
        chk("w4_rst_cnt", {30'b0, cnt4}, 0);
        rst4 = 0; a4 = 4'b0001; b4 = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("w4_sat_cnt_%0d", k), {30'b0, cnt4}, exp_cnt(k, 2));
        end
        iv4 = 0;
        rst4 = 1;
        step();
        chk("w4_sat_rst_cnt", {30'b0, cnt4}, 0);
        rst4 = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
